// File: rtl/lag_pl_buffers.sv
// lag_pl_buffers: n independent first-word-fall-through FIFOs, one per
// physical lane, each `size` flits deep and built from flip-flops.
// Optional macro LAG_PL_BUF_CHECK_EN adds simulation-only checks that report
// a push into a full FIFO (with no pop) and a pop from an empty FIFO.

package lag_pl_pkg;
  // Flit carried through the lane buffers.
  typedef logic [15:0] flit_t;

  // Per-FIFO status, decoded from registered occupancy only.
  typedef struct packed {
    logic full;
    logic empty;
    logic nearly_full;
    logic nearly_empty;
  } fifov_flags_t;
endpackage

module lag_pl_buffers
  import lag_pl_pkg::*;
#(
  parameter int size = 8,
  parameter int n    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] push,
  input  logic [n-1:0] pop,
  input  flit_t        data_in  [n],
  output flit_t        data_out [n],
  output fifov_flags_t flags    [n]
);

  localparam int PTR_W = $clog2(size);
  localparam int CNT_W = $clog2(size + 1);

  localparam logic [CNT_W-1:0] SIZE_C   = CNT_W'(size);
  localparam logic [CNT_W-1:0] SIZE_M1  = CNT_W'(size - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(size - 1);

  genvar gi;
  generate
    for (gi = 0; gi < n; gi++) begin : g_fifo
      flit_t            mem_reg [size];
      logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
      logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
      logic [CNT_W-1:0] count_reg, count_next;
      logic             do_push, do_pop;

      // Accept/ignore decisions and next-state for pointers and occupancy.
      // A full FIFO still accepts a push when a pop frees a slot the same
      // cycle; a pop on empty is dropped even if a push arrives with it.
      always_comb begin
        do_pop      = pop[gi] && (count_reg != '0);
        do_push     = push[gi] && ((count_reg != SIZE_C) || do_pop);
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (do_pop) begin
          rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end
        if (do_push) begin
          wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count_next = count_reg + 1'b1;
          2'b01:   count_next = count_reg - 1'b1;
          default: count_next = count_reg;
        endcase
      end

      // Pointer and occupancy registers; reset empties the FIFO at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          rd_ptr_reg <= rd_ptr_next;
          wr_ptr_reg <= wr_ptr_next;
          count_reg  <= count_next;
        end
      end

      // Flit storage; contents are don't-care once pointers are reset.
      always_ff @(posedge clk) begin
        if (do_push) begin
          mem_reg[wr_ptr_reg] <= data_in[gi];
        end
      end

      // Head flit falls through with no read latency; zero while empty.
      assign data_out[gi] = (count_reg == '0) ? '0 : mem_reg[rd_ptr_reg];

      assign flags[gi].full         = (count_reg == SIZE_C);
      assign flags[gi].empty        = (count_reg == '0);
      assign flags[gi].nearly_full  = (count_reg == SIZE_M1);
      assign flags[gi].nearly_empty = (count_reg == ONE_C);

`ifdef LAG_PL_BUF_CHECK_EN
      // Report misuse of this lane's FIFO, naming the FIFO index.
      always @(posedge clk) begin
        if (rst_n) begin
          if (push[gi] && !pop[gi] && (count_reg == SIZE_C)) begin
            $error("lag_pl_buffers: push to full FIFO %0d without pop", gi);
          end
          if (pop[gi] && (count_reg == '0)) begin
            $error("lag_pl_buffers: pop from empty FIFO %0d", gi);
          end
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_lag_pl_buffers.sv
// Testbench for lag_pl_buffers: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_lag_pl_buffers;
  import lag_pl_pkg::*;

  localparam int N    = 4;
  localparam int SIZE = 8;

  localparam logic [3:0] F_EMPTY = 4'b0100;
  localparam logic [3:0] F_NE    = 4'b0001;
  localparam logic [3:0] F_NF    = 4'b0010;
  localparam logic [3:0] F_FULL  = 4'b1000;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  flit_t        data_in  [N];
  flit_t        data_out [N];
  fifov_flags_t flags    [N];

  int n_assert = 0;
  int n_fail   = 0;

  flit_t mq [N][$];

  lag_pl_buffers #(.size(SIZE), .n(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is a bounded queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        bit popped;
        popped = pop[i] && (mq[i].size() > 0);
        if (push[i] && (mq[i].size() < SIZE || popped)) begin
          if (popped) void'(mq[i].pop_front());
          mq[i].push_back(data_in[i]);
        end else if (popped) begin
          void'(mq[i].pop_front());
        end
      end
    end
  end

  function automatic logic [15:0] exp_data(input int i);
    return (mq[i].size() == 0) ? 16'h0 : mq[i][0];
  endfunction

  function automatic logic [3:0] exp_flags(input int i);
    int c;
    c = mq[i].size();
    return {c == SIZE, c == 0, c == SIZE - 1, c == 1};
  endfunction

  // Compare every FIFO against the model away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_data[%0d]", i), 32'(data_out[i]), 32'(exp_data(i)));
      chk($sformatf("model_flags[%0d]", i), 32'(flags[i]), 32'(exp_flags(i)));
    end
  end

  // One operation on FIFO k; other lanes see unrelated data but no strobes.
  task automatic op(input int k, input bit pu, input bit po, input flit_t v);
    @(negedge clk); #1;
    push = '0;
    pop  = '0;
    push[k] = pu;
    pop[k]  = po;
    for (int j = 0; j < N; j++) data_in[j] = v ^ flit_t'(16'h1111 * (j + 1));
    data_in[k] = v;
    @(posedge clk); #1;
    push = '0;
    pop  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    push  = '0;
    pop   = '0;
    for (int j = 0; j < N; j++) data_in[j] = '0;

    // Reset and idle: everything empty, outputs zero.
    #3;
    for (int i = 0; i < N; i++) chk("in_reset_flags", 32'(flags[i]), 32'(F_EMPTY));
    #9 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("idle_flags", 32'(flags[i]), 32'(F_EMPTY));
      chk("idle_data", 32'(data_out[i]), 32'h0);
    end

    // FIFO 2: A, B, C in, then out in order.
    op(2, 1, 0, 16'hA001);
    chk("f2_head_after_A", 32'(data_out[2]), 32'hA001);
    chk("f2_ne_after_A", 32'(flags[2]), 32'(F_NE));
    op(2, 1, 0, 16'hB002);
    op(2, 1, 0, 16'hC003);
    chk("f2_head_A", 32'(data_out[2]), 32'hA001);
    op(2, 0, 1, 16'h0);
    chk("f2_head_B", 32'(data_out[2]), 32'hB002);
    op(2, 0, 1, 16'h0);
    chk("f2_head_C", 32'(data_out[2]), 32'hC003);
    op(2, 0, 1, 16'h0);
    chk("f2_drained_data", 32'(data_out[2]), 32'h0);
    chk("f2_drained_flags", 32'(flags[2]), 32'(F_EMPTY));
    chk("f0_untouched", 32'(flags[0]), 32'(F_EMPTY));
    chk("f3_untouched", 32'(flags[3]), 32'(F_EMPTY));

    // FIFO 0: fill to full, overflow ignored, drain exactly.
    for (int j = 1; j <= 7; j++) op(0, 1, 0, flit_t'(16'h0100 + j));
    chk("f0_nearly_full", 32'(flags[0]), 32'(F_NF));
    op(0, 1, 0, 16'h0108);
    chk("f0_full", 32'(flags[0]), 32'(F_FULL));
    op(0, 1, 0, 16'hDEAD);
    chk("f0_full_after_overflow", 32'(flags[0]), 32'(F_FULL));
    chk("f0_head_after_overflow", 32'(data_out[0]), 32'h0101);
    for (int j = 1; j <= 8; j++) begin
      chk($sformatf("f0_pop_%0d", j), 32'(data_out[0]), 32'(16'h0100 + j));
      op(0, 0, 1, 16'h0);
    end
    chk("f0_empty_after_drain", 32'(flags[0]), 32'(F_EMPTY));

    // FIFO 1: push+pop on full keeps count, X comes out 8th.
    for (int j = 1; j <= 8; j++) op(1, 1, 0, flit_t'(16'h1100 + j));
    op(1, 1, 1, 16'h5A5A);
    chk("f1_full_after_pushpop", 32'(flags[1]), 32'(F_FULL));
    for (int j = 2; j <= 8; j++) begin
      chk($sformatf("f1_pop_%0d", j), 32'(data_out[1]), 32'(16'h1100 + j));
      op(1, 0, 1, 16'h0);
    end
    chk("f1_X_eighth", 32'(data_out[1]), 32'h5A5A);
    op(1, 0, 1, 16'h0);
    chk("f1_empty", 32'(flags[1]), 32'(F_EMPTY));

    // FIFO 3: push+pop on empty keeps the push only.
    op(3, 1, 1, 16'h7E57);
    chk("f3_ne_after_pushpop", 32'(flags[3]), 32'(F_NE));
    chk("f3_head_Y", 32'(data_out[3]), 32'h7E57);
    op(3, 0, 1, 16'h0);

    // Mixed traffic on all lanes, exercising wraparound and full/empty edges.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      push = N'($urandom);
      pop  = (c < 200) ? N'($urandom) & N'($urandom) : N'($urandom);
      for (int j = 0; j < N; j++) data_in[j] = flit_t'($urandom);
    end
    @(negedge clk); #1;
    push = '0;
    pop  = '0;

    // Mid-cycle asynchronous reset discards stored flits.
    for (int i = 0; i < N; i++) begin
      while (mq[i].size() > 0) op(i, 0, 1, 16'h0);
    end
    for (int j = 1; j <= 5; j++) op(0, 1, 0, flit_t'(16'h0500 + j));
    chk("f0_five_head", 32'(data_out[0]), 32'h0501);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 32'(flags[0]), 32'(F_EMPTY));
    chk("async_reset_data", 32'(data_out[0]), 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    push[0]    = 1'b1;
    data_in[0] = 16'h7777;
    @(posedge clk); #1;
    push = '0;
    chk("first_push_after_reset_data", 32'(data_out[0]), 32'h7777);
    chk("first_push_after_reset_flags", 32'(flags[0]), 32'(F_NE));
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
